dds_wave_shaper: RTL

- Downstream neighbour of the DDS phase accumulator.
- Consumes the 32-bit accumulated phase and converts it to a signed 16-bit audio sample.
- Four waveforms are selectable: saw, square, triangle and LFSR noise.
- The waveform is scaled by a gate-driven linear attack/release envelope and fed to the DAC/PWM stage.

---
 rtl/dds_wave_shaper_if.sv | 22 ++
 rtl/dds_wave_shaper.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dds_wave_shaper_if.sv
// Bus between the DDS phase accumulator side and the wave shaper.
// The master drives phase and envelope controls, and the slave returns the sample and envelope status.
interface dds_wave_shaper_if;
  logic [31:0] PHASE;
  logic [1:0]  WAVE;
  logic        GATE;
  logic [15:0] ATTACK;
  logic [15:0] RELEASE;
  logic [15:0] SAMPLE;
  logic [15:0] ENV;
  logic [1:0]  ENV_STATE;

  modport master (
    output PHASE, WAVE, GATE, ATTACK, RELEASE,
    input  SAMPLE, ENV, ENV_STATE
  );

  modport slave (
    input  PHASE, WAVE, GATE, ATTACK, RELEASE,
    output SAMPLE, ENV, ENV_STATE
  );
endinterface

// File: rtl/dds_wave_shaper.sv
// Phase-to-sample wave shaper: it produces saw, square, triangle or LFSR noise and scales it by a linear AR envelope.
// Define DDS_WAVE_SHAPER_ENV_EN to build the gate-driven envelope FSM; otherwise the level is fixed at full scale.
module dds_wave_shaper #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic CLK,
  input logic RESET,
  dds_wave_shaper_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [15:0]        raw;
  logic [15:0]        raw_next;
  logic [15:0]        tri_fold;
  logic [15:0]        sample;
  logic [15:0]        env;
  env_state_t         state;
  logic signed [32:0] product;
  logic               unused_product_bits;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tri_fold = bus.PHASE[31] ? ~bus.PHASE[30:15] : bus.PHASE[30:15];

  // Each waveform maps to signed 16-bit; square avoids 8000 so its two halves are symmetric.
  always_comb begin
    raw_next = '0;
    case (bus.WAVE)
      2'd0:    raw_next = {~bus.PHASE[31], bus.PHASE[30:16]};
      2'd1:    raw_next = bus.PHASE[31] ? 16'h8001 : 16'h7FFF;
      2'd2:    raw_next = tri_fold ^ 16'h8000;
      default: raw_next = lfsr;
    endcase
  end

  // Signed sample times unsigned level; bits [31:16] give an arithmetic shift by 16 toward -inf.
  assign product = $signed({{17{raw[15]}}, raw}) * $signed({17'b0, env});
  assign unused_product_bits = ^{product[32], product[15:0]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lfsr   <= LFSR_SEED;
      raw    <= '0;
      sample <= '0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr_fb};
      raw    <= raw_next;
      sample <= product[31:16];
    end
  end

`ifdef DDS_WAVE_SHAPER_ENV_EN
  env_state_t  state_next;
  logic [15:0] env_next;
  logic [16:0] attack_sum;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      env   <= '0;
    end else begin
      state <= state_next;
      env   <= env_next;
    end
  end

  // A zero ATTACK or RELEASE rate means an instant jump to the end level. A retrigger continues from the current level.
  always_comb begin
    state_next = state;
    env_next   = env;
    attack_sum = {1'b0, env} + {1'b0, bus.ATTACK};
    case (state)
      ST_IDLE: begin
        env_next = '0;
        if (bus.GATE) state_next = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!bus.GATE) begin
          state_next = ST_RELEASE;
        end else if (bus.ATTACK == 16'h0000 || attack_sum[16] || attack_sum[15:0] == 16'hFFFF) begin
          env_next   = 16'hFFFF;
          state_next = ST_SUSTAIN;
        end else begin
          env_next = attack_sum[15:0];
        end
      end
      ST_SUSTAIN: begin
        env_next = 16'hFFFF;
        if (!bus.GATE) state_next = ST_RELEASE;
      end
      default: begin
        if (bus.GATE) begin
          state_next = ST_ATTACK;
        end else if (bus.RELEASE == 16'h0000 || bus.RELEASE >= env) begin
          env_next   = '0;
          state_next = ST_IDLE;
        end else begin
          env_next = env - bus.RELEASE;
        end
      end
    endcase
  end
`else
  logic unused_env_inputs;

  assign env   = 16'hFFFF;
  assign state = ST_SUSTAIN;
  assign unused_env_inputs = ^{bus.GATE, bus.ATTACK, bus.RELEASE};
`endif

  assign bus.SAMPLE    = sample;
  assign bus.ENV       = env;
  assign bus.ENV_STATE = state;

endmodule
